// File: rtl/vga_pkg.sv
// vga_pkg: shared timing defaults, colour types, pattern selector and bar-index helper.
package vga_pkg;

  localparam int unsigned DEF_TOTAL_WIDTH   = 800;
  localparam int unsigned DEF_TOTAL_HEIGHT  = 525;
  localparam int unsigned DEF_ACTIVE_WIDTH  = 640;
  localparam int unsigned DEF_ACTIVE_HEIGHT = 480;
  localparam int unsigned VIDEO_WIDTH       = 3;
  localparam int unsigned CNT_W             = 10;

  typedef enum logic [2:0] {
    PAT_BLACK,
    PAT_RED,
    PAT_GREEN,
    PAT_BLUE,
    PAT_CHECKER,
    PAT_BARS,
    PAT_BORDER,
    PAT_GRADIENT
  } pattern_e;

  typedef struct packed {
    logic [VIDEO_WIDTH-1:0] r;
    logic [VIDEO_WIDTH-1:0] g;
    logic [VIDEO_WIDTH-1:0] b;
  } rgb_t;

  // Bar index 0..7 from a chain of constant-threshold comparisons (no divider).
  function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] col,
                                           input logic [CNT_W-1:0] bar_w);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if ({3'b000, col} >= 13'(k) * {3'b000, bar_w}) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: raw sync/pattern inputs from the timing generator and VGA pin outputs.
//   master: drives i_HSync, i_VSync, i_Pattern; observes outputs
//   slave : pattern generator side
interface vga_pattern_gen_if;
  logic                            i_HSync;
  logic                            i_VSync;
  logic [2:0]                      i_Pattern;
  logic                            o_HSync;
  logic                            o_VSync;
  logic [vga_pkg::VIDEO_WIDTH-1:0] o_Red;
  logic [vga_pkg::VIDEO_WIDTH-1:0] o_Grn;
  logic [vga_pkg::VIDEO_WIDTH-1:0] o_Blu;
  logic                            o_Locked;
  logic                            o_Resync_Err;

  modport master (
    output i_HSync, i_VSync, i_Pattern,
    input  o_HSync, o_VSync, o_Red, o_Grn, o_Blu, o_Locked, o_Resync_Err
  );

  modport slave (
    input  i_HSync, i_VSync, i_Pattern,
    output o_HSync, o_VSync, o_Red, o_Grn, o_Blu, o_Locked, o_Resync_Err
  );
endinterface

// File: rtl/vga_sync_to_count.sv
// vga_sync_to_count: stage 1. Registers the raw syncs, detects frame start
// (VSync rising vs. its registered copy) and recovers column/row counters.
//   i_Clk, i_Rst         clock, synchronous active-high reset
//   i_HSync, i_VSync     raw syncs
//   o_HSync1, o_VSync1   registered syncs (pixel at o_Col/o_Row)
//   o_Col, o_Row         coordinate of the registered pixel
//   o_FrameStart         combinational frame-start strobe (input pixel is (0,0))
//   o_Locked             set by the first frame start after reset
//   o_Resync_Err         one-clock pulse when a frame start arrives off-count
module vga_sync_to_count
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL_WIDTH  = DEF_TOTAL_WIDTH,
  parameter int unsigned TOTAL_HEIGHT = DEF_TOTAL_HEIGHT
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_HSync,
  input  logic             i_VSync,
  output logic             o_HSync1,
  output logic             o_VSync1,
  output logic [CNT_W-1:0] o_Col,
  output logic [CNT_W-1:0] o_Row,
  output logic             o_FrameStart,
  output logic             o_Locked,
  output logic             o_Resync_Err
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_WIDTH - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_HEIGHT - 1);

  logic             hsync1_q, vsync1_q;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  logic             locked_q, err_q;
  logic             fs;

  assign fs = i_VSync & ~vsync1_q;

  always_comb begin
    col_d = col_q + CNT_W'(1);
    row_d = row_q;
    if (fs) begin
      col_d = '0;
      row_d = '0;
    end else if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      hsync1_q <= 1'b1;
      vsync1_q <= 1'b1;
      col_q    <= '0;
      row_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      hsync1_q <= i_HSync;
      vsync1_q <= i_VSync;
      col_q    <= col_d;
      row_q    <= row_d;
      // Counters still hold the previous pixel, which must be the last of the frame.
      err_q    <= fs && locked_q && !((col_q == COL_LAST) && (row_q == ROW_LAST));
      if (fs) locked_q <= 1'b1;
    end
  end

  assign o_HSync1     = hsync1_q;
  assign o_VSync1     = vsync1_q;
  assign o_Col        = col_q;
  assign o_Row        = row_q;
  assign o_FrameStart = fs;
  assign o_Locked     = locked_q;
  assign o_Resync_Err = err_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: recovers pixel position from raw syncs and drives a selectable
// test pattern with syncs delayed to stay aligned with colour (2-clock latency).
//   i_Clk, i_Rst  pixel clock, synchronous active-high reset
//   bus           vga_pattern_gen_if.slave: i_HSync/i_VSync/i_Pattern in,
//                 o_HSync/o_VSync/o_Red/o_Grn/o_Blu/o_Locked/o_Resync_Err out
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL_WIDTH   = DEF_TOTAL_WIDTH,
  parameter int unsigned TOTAL_HEIGHT  = DEF_TOTAL_HEIGHT,
  parameter int unsigned ACTIVE_WIDTH  = DEF_ACTIVE_WIDTH,
  parameter int unsigned ACTIVE_HEIGHT = DEF_ACTIVE_HEIGHT
) (
  input logic               i_Clk,
  input logic               i_Rst,
  vga_pattern_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0] ACT_W = CNT_W'(ACTIVE_WIDTH);
  localparam logic [CNT_W-1:0] ACT_H = CNT_W'(ACTIVE_HEIGHT);
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'(ACTIVE_WIDTH / 8);

  logic             hsync1, vsync1, fs, locked, resync_err;
  logic [CNT_W-1:0] col, row;

  pattern_e   pat_q;
  logic [7:0] frame_q;
  logic       hsync2_q, vsync2_q;
  rgb_t       rgb_q, rgb_d;
  logic       active;
  logic [2:0] bar;

  vga_sync_to_count #(
    .TOTAL_WIDTH (TOTAL_WIDTH),
    .TOTAL_HEIGHT(TOTAL_HEIGHT)
  ) u_sync (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_HSync     (bus.i_HSync),
    .i_VSync     (bus.i_VSync),
    .o_HSync1    (hsync1),
    .o_VSync1    (vsync1),
    .o_Col       (col),
    .o_Row       (row),
    .o_FrameStart(fs),
    .o_Locked    (locked),
    .o_Resync_Err(resync_err)
  );

  always_comb begin
    rgb_d  = '0;
    active = (col < ACT_W) && (row < ACT_H);
    bar    = bar_index(col, BAR_W);
    if (active && locked) begin
      unique case (pat_q)
        PAT_BLACK:    rgb_d = '0;
        PAT_RED:      rgb_d.r = '1;
        PAT_GREEN:    rgb_d.g = '1;
        PAT_BLUE:     rgb_d.b = '1;
        PAT_CHECKER:  if (col[5] ^ row[5]) rgb_d = '1;
        PAT_BARS: begin
          rgb_d.r = {VIDEO_WIDTH{bar[0]}};
          rgb_d.g = {VIDEO_WIDTH{bar[1]}};
          rgb_d.b = {VIDEO_WIDTH{bar[2]}};
        end
        PAT_BORDER: begin
          if ((col == '0) || (col == ACT_W - CNT_W'(1)) ||
              (row == '0) || (row == ACT_H - CNT_W'(1))) rgb_d = '1;
        end
        PAT_GRADIENT: begin
          rgb_d.r = col[7:5];
          rgb_d.g = row[7:5];
          rgb_d.b = frame_q[5:3];
        end
        default:      rgb_d = '0;
      endcase
    end
  end

  // Pattern and frame count change on the same edge the counters restart,
  // so a new selection applies from pixel (0,0) onward.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      pat_q    <= PAT_BLACK;
      frame_q  <= '0;
      hsync2_q <= 1'b1;
      vsync2_q <= 1'b1;
      rgb_q    <= '0;
    end else begin
      if (fs) begin
        pat_q   <= pattern_e'(bus.i_Pattern);
        frame_q <= frame_q + 8'd1;
      end
      hsync2_q <= hsync1;
      vsync2_q <= vsync1;
      rgb_q    <= rgb_d;
    end
  end

  assign bus.o_HSync      = hsync2_q;
  assign bus.o_VSync      = vsync2_q;
  assign bus.o_Red        = rgb_q.r;
  assign bus.o_Grn        = rgb_q.g;
  assign bus.o_Blu        = rgb_q.b;
  assign bus.o_Locked     = locked;
  assign bus.o_Resync_Err = resync_err;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: drives a timing-generator model into vga_pattern_gen and
// checks every output cycle against a pixel-level model of the pattern rules.
module tb_vga_pattern_gen;

  localparam int TW = 800;
  localparam int TH = 10;
  localparam int AW = 640;
  localparam int AH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_pattern_gen_if vif ();

  vga_pattern_gen #(
    .TOTAL_WIDTH  (TW),
    .TOTAL_HEIGHT (TH),
    .ACTIVE_WIDTH (AW),
    .ACTIVE_HEIGHT(AH)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (vif)
  );

  typedef struct {
    bit         rst;
    bit         hs;
    bit         vs;
    logic [8:0] rgb;
    bit         locked;
    bit         err;
    int         x;
    int         y;
    int         pat;
  } exp_t;

  typedef struct {
    int         pat;
    int         x;
    int         y;
    logic [8:0] rgb;
  } probe_t;

  localparam int NPROBE = 15;
  probe_t probes [NPROBE] = '{
    '{1, 0,   0, 9'o700}, '{1, 639, 7, 9'o700}, '{1, 640, 0, 9'o000},
    '{1, 0,   8, 9'o000}, '{5, 80,  0, 9'o700}, '{5, 159, 2, 9'o700},
    '{5, 240, 0, 9'o770}, '{5, 560, 0, 9'o777}, '{5, 639, 5, 9'o777},
    '{4, 32,  0, 9'o777}, '{4, 0,   0, 9'o000}, '{6, 0,   0, 9'o777},
    '{6, 639, 3, 9'o777}, '{6, 10,  3, 9'o000}, '{6, 10,  7, 9'o777}
  };
  int probe_hits [NPROBE];

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pulses = 0;

  // Generator and model state
  int gx = 0, gy = 0, prev_gx = 0, prev_gy = 0;
  bit force_low = 1'b0;
  int pat_in = 0;
  bit m_locked = 1'b0, m_prev_vs = 1'b1;
  int m_pat = 0, m_frame = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model_rgb(input int p, input int x, input int y, input int frame);
    logic [2:0] r, g, b;
    int idx;
    r = 0; g = 0; b = 0;
    if (x < AW && y < AH) begin
      case (p)
        1: r = 7;
        2: g = 7;
        3: b = 7;
        4: if (((x / 32) % 2) != ((y / 32) % 2)) begin r = 7; g = 7; b = 7; end
        5: begin
          idx = x / (AW / 8);
          r = (idx % 2 != 0) ? 3'd7 : 3'd0;
          g = ((idx / 2) % 2 != 0) ? 3'd7 : 3'd0;
          b = ((idx / 4) % 2 != 0) ? 3'd7 : 3'd0;
        end
        6: if (x == 0 || x == AW - 1 || y == 0 || y == AH - 1) begin r = 7; g = 7; b = 7; end
        7: begin
          r = 3'((x / 32) % 8);
          g = 3'((y / 32) % 8);
          b = 3'((frame / 8) % 8);
        end
        default: ;
      endcase
    end
    return {r, g, b};
  endfunction

  // Apply one input pixel, record what it must produce, then wait for the next negedge.
  task automatic drive(input bit r, input bit hs, input bit vs);
    exp_t e;
    bit fs;
    e.rst = r;
    if (r) begin
      m_locked = 0; m_prev_vs = 1; m_pat = 0; m_frame = 0;
      e.hs = 1; e.vs = 1; e.rgb = 0; e.err = 0;
    end else begin
      fs = vs && !m_prev_vs;
      e.err = fs && m_locked && !(prev_gx == TW - 1 && prev_gy == TH - 1);
      if (fs) begin
        m_pat = pat_in; m_frame = (m_frame + 1) % 256; m_locked = 1;
      end
      m_prev_vs = vs;
      e.hs = hs; e.vs = vs;
      e.rgb = m_locked ? model_rgb(m_pat, gx, gy, m_frame) : 9'd0;
    end
    e.locked = m_locked; e.x = gx; e.y = gy; e.pat = m_pat;
    prev_gx = gx; prev_gy = gy;
    exp_q.push_back(e);
    rst = r;
    vif.i_HSync = hs;
    vif.i_VSync = vs;
    vif.i_Pattern = 3'(pat_in);
    @(negedge clk);
  endtask

  task automatic gen_step(input bit r);
    drive(r, gx < 704, force_low ? 1'b0 : (gy < TH - 2));
    if (gx == TW - 1) begin
      gx = 0;
      gy = (gy == TH - 1) ? 0 : gy + 1;
    end else begin
      gx++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) gen_step(1'b0);
  endtask

  // Compare process: outputs after edge k reflect stage-2 of pixel k-1, stage-1 flags of pixel k.
  always @(posedge clk) begin
    exp_t cur, prv;
    logic [8:0] act_rgb;
    #2;
    act_rgb = {vif.o_Red, vif.o_Grn, vif.o_Blu};
    if (vif.o_Resync_Err === 1'b1) n_pulses++;
    if (exp_q.size() > 0) begin
      cur = exp_q[exp_q.size() - 1];
      if (cur.rst) begin
        chk("rst_hsync", 32'(vif.o_HSync), 32'd1);
        chk("rst_vsync", 32'(vif.o_VSync), 32'd1);
        chk("rst_rgb",   32'(act_rgb), 32'd0);
      end else if (exp_q.size() > 1) begin
        prv = exp_q[exp_q.size() - 2];
        chk("hsync_dly2", 32'(vif.o_HSync), 32'(prv.hs));
        chk("vsync_dly2", 32'(vif.o_VSync), 32'(prv.vs));
        chk("rgb",        32'(act_rgb), 32'(prv.rgb));
        if (prv.locked && !prv.rst) begin
          for (int i = 0; i < NPROBE; i++) begin
            if (probes[i].pat == prv.pat && probes[i].x == prv.x && probes[i].y == prv.y) begin
              probe_hits[i]++;
              chk($sformatf("probe_p%0d_x%0d_y%0d", prv.pat, prv.x, prv.y),
                  32'(act_rgb), 32'(probes[i].rgb));
            end
          end
        end
      end
      chk("locked",     32'(vif.o_Locked), 32'(cur.locked));
      chk("resync_err", 32'(vif.o_Resync_Err), 32'(cur.err));
      while (exp_q.size() > 1) void'(exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    int all_hit;
    // Reset with toggling syncs
    for (int i = 0; i < 3; i++) drive(1'b1, 1'(i % 2), 1'(1 - i % 2));
    chk("reset_locked", 32'(vif.o_Locked), 32'd0);

    // Start two rows before frame start; pattern 1 frame, then bars
    gx = 0; gy = TH - 2; pat_in = 1;
    run(2 * TW);
    run(TW * TH);
    pat_in = 5;
    run(TW * TH);

    // Red frame with a mid-frame switch to checker, then checker frame
    pat_in = 1;
    run(6 * TW);
    pat_in = 4;
    run(4 * TW);
    run(TW * TH - 10);
    pat_in = 6;
    run(10);

    // Border frame, early frame start at row 4
    run(4 * TW + 100);
    force_low = 1'b1;
    run(5);
    force_low = 1'b0;
    gx = 0; gy = 0;
    run(TW * TH - 10);
    pat_in = 7;
    run(10);
    run(5 * TW);
    chk("resync_pulse_count", 32'(n_pulses), 32'd1);
    chk("locked_after_resync", 32'(vif.o_Locked), 32'd1);

    // Reset mid-frame, relock at next frame start
    for (int i = 0; i < 3; i++) gen_step(1'b1);
    chk("midreset_locked", 32'(vif.o_Locked), 32'd0);
    run(5 * TW - 3 + 2 * TW);
    chk("relocked", 32'(vif.o_Locked), 32'd1);

    all_hit = 1;
    for (int i = 0; i < NPROBE; i++) if (probe_hits[i] == 0) all_hit = 0;
    chk("all_probes_reached", 32'(all_hit), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
